rx_slot_buffer: RTL and testbench
=================================

Name: rx_slot_buffer

Overview:
- Sits directly downstream of the NPUSCH resource-element demapper in the receive chain.
- Collects one uplink slot of 7 demapped SC-FDMA symbols (12 complex subcarriers each).
- Routes the DMRS symbol to the channel estimator as soon as it arrives and holds the 6 data symbols.
- Once the estimate is ready, streams the held data symbols to the equalizer under a valid/ready handshake.

Parameters:
- DW, 16, signed width of each real/imag sample.
- NSC, 12, subcarriers per symbol.
- NSYM, 7, SC-FDMA symbols per slot.
- DMRS_IDX, 3, symbol index within the slot that carries DMRS.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  one demapped symbol is present on i_re/i_im.
- i_slot_start  in  1  qualifies i_valid; marks symbol 0 of a slot.
- i_re  in  DW x NSC  signed real parts.
- i_im  in  DW x NSC  signed imaginary parts.
- i_chest_done  in  1  pulse: channel estimate for the current slot is available.
- i_data_ready  in  1  equalizer accepts a data symbol.
- o_dmrs_re  out  DW x NSC  registered DMRS symbol, real.
- o_dmrs_im  out  DW x NSC  registered DMRS symbol, imaginary.
- o_dmrs_valid  out  1  one-cycle pulse.
- o_data_re  out  DW x NSC  data symbol, real.
- o_data_im  out  DW x NSC  data symbol, imaginary.
- o_data_valid  out  1  data symbol is valid.
- o_data_idx  out  3  data symbol number, 0..5, in slot order with DMRS skipped.
- o_data_last  out  1  high with data symbol 5.
- o_busy  out  1  high in any state other than IDLE.
- o_overflow  out  1  one-cycle pulse: input symbol dropped.
- o_slot_err  out  1  one-cycle pulse: partial slot discarded.

Behaviour:
- Reset: all outputs 0, the state returns to IDLE, the symbol counter is 0, and the estimate-seen latch is cleared. Buffer contents are don't-care.
- States and transitions:
  - IDLE -> FILL on i_valid && i_slot_start. That symbol is counted as index 0.
  - In IDLE, i_valid without i_slot_start is dropped and pulses o_overflow.
  - FILL: every i_valid increments sym_cnt (0..NSYM-1).
    - Symbol DMRS_IDX is registered to o_dmrs_re/im, and o_dmrs_valid pulses the next cycle (latency 1).
    - The other symbols are written to a 6-entry buffer at slot wr_ptr, which increments per data symbol.
  - Accepting symbol NSYM-1 moves FILL -> WAIT_EST.
  - WAIT_EST -> DRAIN on the estimate-seen latch or on i_chest_done in the same cycle.
  - The estimate-seen latch sets on i_chest_done in any state except IDLE, and clears on entry to DRAIN. An i_chest_done that arrives during FILL right after the DMRS is therefore honoured.
  - DRAIN: the output presents buffer[rd_ptr]. It advances when o_data_valid && i_data_ready.
    - o_data_valid is held and the data stays stable while i_data_ready is low.
    - After the handshake on symbol 5, DRAIN -> IDLE, and o_data_valid drops the next cycle.
- Mid-slot restart: i_valid && i_slot_start in FILL with sym_cnt != 0 pulses o_slot_err. The partial slot is discarded, and the new symbol is taken as index 0 (wr_ptr reset).
- Inputs in WAIT_EST/DRAIN: i_valid is dropped and o_overflow pulses. There is no back-pressure to upstream.
- Simultaneous events:
  - i_chest_done in the same cycle as the last FILL symbol sets the latch, so DRAIN follows after one WAIT_EST cycle.
  - i_rst takes priority over everything. A reset mid-DRAIN drops o_data_valid the next cycle.
- Samples pass through bit-exact. There is no arithmetic; the pointers wrap only by explicit reset to 0.

Decomposition:
- Shared package rx_pkg:
  - DW, NSC, NSYM, DMRS_IDX constants.
  - A typedef cplx_sym_t: a struct of signed [DW-1:0] re/im arrays [NSC].
  - A state enum {IDLE, FILL, WAIT_EST, DRAIN}.
- One natural sub-module: rx_sym_ram, a 6-deep by (2*DW*NSC)-bit register file with one write port and one read port (asynchronous read). The FSM, counters and DMRS register stay in the top level.

Test Plan:
- Full slot: drive 7 symbols with i_re[k]=16*s+k (s = symbol index), i_im=-i_re, then pulse i_chest_done with i_data_ready=1.
  - Response: o_dmrs_valid one cycle after symbol 3, carrying re[0]=48.
  - Then 6 consecutive o_data_valid beats with idx 0..5 carrying symbols 0,1,2,4,5,6; o_data_last on the 6th beat; o_busy low after it.
- Early estimate: i_chest_done 2 cycles after DMRS, during FILL -> DRAIN starts one cycle after WAIT_EST is entered, with no further i_chest_done needed.
- Back-pressure: toggle i_data_ready 1,0,0,1 -> o_data_valid stays high and o_data_re is stable through the stall; each symbol is delivered exactly once.
- Restart: i_slot_start with symbol 4 of a slot -> o_slot_err pulse. The next 7 symbols form a clean slot and the DMRS comes from the new index 3.
- Overflow: i_valid during DRAIN with symbol value 0x7FFF -> o_overflow pulse, and the drained data is unchanged.
- Reset mid-DRAIN after 2 beats -> the next cycle has o_data_valid=0 and o_busy=0. A following full slot behaves as in the full-slot test.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and types for the NPUSCH receive slot buffer.
// One symbol is NSC complex samples; a slot is NSYM symbols with DMRS at DMRS_IDX.
package rx_pkg;

    localparam int DW       = 16;
    localparam int NSC      = 12;
    localparam int NSYM     = 7;
    localparam int DMRS_IDX = 3;
    localparam int NDATA    = NSYM - 1;

    typedef logic signed [DW-1:0] sample_t;

    typedef struct packed {
        sample_t [NSC-1:0] re;
        sample_t [NSC-1:0] im;
    } cplx_sym_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_EST,
        DRAIN
    } state_t;

    typedef logic [2:0] idx_t;

    localparam idx_t LAST_SYM  = idx_t'(NSYM - 1);
    localparam idx_t DMRS_SYM  = idx_t'(DMRS_IDX);
    localparam idx_t LAST_DATA = idx_t'(NDATA - 1);

endpackage

// File: rtl/rx_sym_ram.sv
// Register file holding the data symbols of one slot.
// One synchronous write port, one asynchronous read port; contents are not reset.
module rx_sym_ram
    import rx_pkg::*;
#(
    parameter int DEPTH = NDATA,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  cplx_sym_t     i_wdata,
    input  logic [AW-1:0] i_raddr,
    output cplx_sym_t     o_rdata
);

    cplx_sym_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_slot_buffer.sv
// Collects one uplink slot, forwards the DMRS symbol immediately and holds the
// six data symbols until the channel estimate is ready, then drains them.
module rx_slot_buffer
    import rx_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_slot_start,
    input  sample_t [NSC-1:0] i_re,
    input  sample_t [NSC-1:0] i_im,
    input  logic              i_chest_done,
    input  logic              i_data_ready,
    output sample_t [NSC-1:0] o_dmrs_re,
    output sample_t [NSC-1:0] o_dmrs_im,
    output logic              o_dmrs_valid,
    output sample_t [NSC-1:0] o_data_re,
    output sample_t [NSC-1:0] o_data_im,
    output logic              o_data_valid,
    output logic [2:0]        o_data_idx,
    output logic              o_data_last,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_slot_err
);

    state_t    r_state;
    state_t    w_state_nxt;
    idx_t      r_sym_cnt;
    idx_t      r_wr_ptr;
    idx_t      r_rd_ptr;
    logic      r_est_seen;
    cplx_sym_t r_dmrs_p1;
    logic      r_dmrs_vld_p1;
    logic      r_overflow;
    logic      r_slot_err;

    logic      w_accept;
    logic      w_restart;
    logic      w_overflow;
    logic      w_hs;
    logic      w_enter_drain;
    logic      w_is_dmrs;
    logic      w_we;
    idx_t      w_sym_idx;
    idx_t      w_waddr;
    cplx_sym_t w_in_sym;
    cplx_sym_t w_rd_sym;

    assign w_in_sym.re = i_re;
    assign w_in_sym.im = i_im;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_restart     = 1'b0;
        w_overflow    = 1'b0;
        w_hs          = 1'b0;
        w_enter_drain = 1'b0;
        w_sym_idx     = r_sym_cnt;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    if (i_slot_start) begin
                        w_accept    = 1'b1;
                        w_sym_idx   = '0;
                        w_state_nxt = FILL;
                    end else begin
                        w_overflow = 1'b1;
                    end
                end
            end
            FILL: begin
                if (i_valid) begin
                    w_accept = 1'b1;
                    // A new slot start mid-slot abandons the partial slot.
                    if (i_slot_start && (r_sym_cnt != '0)) begin
                        w_restart = 1'b1;
                        w_sym_idx = '0;
                    end
                    if (w_sym_idx == LAST_SYM) begin
                        w_state_nxt = WAIT_EST;
                    end
                end
            end
            WAIT_EST: begin
                w_overflow = i_valid;
                if (r_est_seen || i_chest_done) begin
                    w_enter_drain = 1'b1;
                    w_state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                w_overflow = i_valid;
                w_hs       = i_data_ready;
                if (i_data_ready && (r_rd_ptr == LAST_DATA)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_is_dmrs = w_accept && (w_sym_idx == DMRS_SYM);
        w_we      = w_accept && !w_is_dmrs;
        w_waddr   = (w_sym_idx == '0) ? '0 : r_wr_ptr;
    end

    // Input capture stage: counters, DMRS register and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sym_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_est_seen    <= 1'b0;
            r_dmrs_p1     <= '0;
            r_dmrs_vld_p1 <= 1'b0;
            r_overflow    <= 1'b0;
            r_slot_err    <= 1'b0;
        end else begin
            r_dmrs_vld_p1 <= w_is_dmrs;
            r_overflow    <= w_overflow;
            r_slot_err    <= w_restart;
            if (w_is_dmrs) begin
                r_dmrs_p1 <= w_in_sym;
            end
            if (w_accept) begin
                r_sym_cnt <= (w_sym_idx == LAST_SYM) ? '0 : w_sym_idx + 3'd1;
            end
            if (w_we) begin
                r_wr_ptr <= w_waddr + 3'd1;
            end
            if (w_accept && (w_sym_idx == LAST_SYM)) begin
                r_wr_ptr <= '0;
            end
            if (w_enter_drain) begin
                r_rd_ptr <= '0;
            end else if (w_hs) begin
                r_rd_ptr <= (r_rd_ptr == LAST_DATA) ? '0 : r_rd_ptr + 3'd1;
            end
            // An estimate arriving before the slot is complete is remembered.
            if (w_enter_drain) begin
                r_est_seen <= 1'b0;
            end else if (i_chest_done && (r_state != IDLE)) begin
                r_est_seen <= 1'b1;
            end
        end
    end

    rx_sym_ram #(
        .DEPTH(NDATA),
        .AW   (3)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_in_sym),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_rd_sym)
    );

    // Output stage: drain presents the buffer entry at the read pointer.
    assign o_dmrs_re    = r_dmrs_p1.re;
    assign o_dmrs_im    = r_dmrs_p1.im;
    assign o_dmrs_valid = r_dmrs_vld_p1;
    assign o_data_valid = (r_state == DRAIN);
    assign o_data_re    = o_data_valid ? w_rd_sym.re : '0;
    assign o_data_im    = o_data_valid ? w_rd_sym.im : '0;
    assign o_data_idx   = o_data_valid ? r_rd_ptr : '0;
    assign o_data_last  = o_data_valid && (r_rd_ptr == LAST_DATA);
    assign o_busy       = (r_state != IDLE);
    assign o_overflow   = r_overflow;
    assign o_slot_err   = r_slot_err;

endmodule

// File: tb/tb_rx_slot_buffer.sv
// Scoreboard bench for rx_slot_buffer: stimulus feeds a slot-level reference
// model that queues expected DMRS and data beats; a monitor pops and compares.
`timescale 1ns/1ps
module tb_rx_slot_buffer;
    import rx_pkg::*;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_slot_start = 1'b0;
    sample_t [NSC-1:0] i_re = '0;
    sample_t [NSC-1:0] i_im = '0;
    logic              i_chest_done = 1'b0;
    logic              i_data_ready = 1'b0;
    sample_t [NSC-1:0] o_dmrs_re;
    sample_t [NSC-1:0] o_dmrs_im;
    logic              o_dmrs_valid;
    sample_t [NSC-1:0] o_data_re;
    sample_t [NSC-1:0] o_data_im;
    logic              o_data_valid;
    logic [2:0]        o_data_idx;
    logic              o_data_last;
    logic              o_busy;
    logic              o_overflow;
    logic              o_slot_err;

    rx_slot_buffer dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_slot_start(i_slot_start),
        .i_re        (i_re),
        .i_im        (i_im),
        .i_chest_done(i_chest_done),
        .i_data_ready(i_data_ready),
        .o_dmrs_re   (o_dmrs_re),
        .o_dmrs_im   (o_dmrs_im),
        .o_dmrs_valid(o_dmrs_valid),
        .o_data_re   (o_data_re),
        .o_data_im   (o_data_im),
        .o_data_valid(o_data_valid),
        .o_data_idx  (o_data_idx),
        .o_data_last (o_data_last),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow),
        .o_slot_err  (o_slot_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_sym(input string nm, input cplx_sym_t act, input cplx_sym_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got re0=%0d im0=%0d re11=%0d, expected re0=%0d im0=%0d re11=%0d",
                      nm, act.re[0], act.im[0], act.re[NSC-1], exp.re[0], exp.im[0], exp.re[NSC-1]);
    endtask

    // ---------------- reference model (slot level) ----------------
    typedef struct {
        cplx_sym_t s;
        int        idx;
    } beat_t;

    cplx_sym_t col[$];
    beat_t     exp_data[$];
    cplx_sym_t exp_dmrs[$];
    int        exp_dmrs_cyc[$];
    int        beat_cyc[$];
    int        exp_ovf = 0, exp_err = 0, obs_ovf = 0, obs_err = 0;

    task automatic model_in(input bit start, input cplx_sym_t s);
        int d;
        beat_t b;
        if (exp_data.size() != 0) begin
            exp_ovf++;
        end else if (col.size() == 0 && !start) begin
            exp_ovf++;
        end else begin
            if (start && col.size() != 0) begin
                exp_err++;
                col.delete();
            end
            col.push_back(s);
            if (col.size() == DMRS_IDX + 1) begin
                exp_dmrs.push_back(s);
                exp_dmrs_cyc.push_back(cyc + 1);
            end
            if (col.size() == NSYM) begin
                d = 0;
                for (int i = 0; i < NSYM; i++) begin
                    if (i != DMRS_IDX) begin
                        b.s   = col[i];
                        b.idx = d;
                        exp_data.push_back(b);
                        d++;
                    end
                end
                col.delete();
            end
        end
    endtask

    task automatic model_reset();
        col.delete();
        exp_data.delete();
        exp_dmrs.delete();
        exp_dmrs_cyc.delete();
    endtask

    function automatic cplx_sym_t pat(input int s);
        cplx_sym_t r;
        for (int k = 0; k < NSC; k++) begin
            r.re[k] = sample_t'(16 * s + k);
            r.im[k] = sample_t'(-(16 * s + k));
        end
        return r;
    endfunction

    function automatic cplx_sym_t rnd_sym();
        cplx_sym_t r;
        for (int k = 0; k < NSC; k++) begin
            r.re[k] = sample_t'($urandom);
            r.im[k] = sample_t'($urandom);
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic      stall_prev = 1'b0;
    cplx_sym_t prev_sym;
    logic [2:0] prev_idx;

    initial begin
        cplx_sym_t cur;
        beat_t     b;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                stall_prev = 1'b0;
            end else begin
                cur = {o_data_re, o_data_im};
                if (o_overflow) obs_ovf++;
                if (o_slot_err) obs_err++;
                if (stall_prev) begin
                    chk("stall_valid", o_data_valid, 1);
                    chk_sym("stall_data", cur, prev_sym);
                    chk("stall_idx", o_data_idx, prev_idx);
                end
                if (o_dmrs_valid) begin
                    chk("dmrs_expected", exp_dmrs.size() != 0, 1);
                    if (exp_dmrs.size() != 0) begin
                        chk_sym("dmrs_data", {o_dmrs_re, o_dmrs_im}, exp_dmrs.pop_front());
                        chk("dmrs_latency", cyc, exp_dmrs_cyc.pop_front());
                    end
                end
                if (o_data_valid && i_data_ready) begin
                    chk("data_expected", exp_data.size() != 0, 1);
                    if (exp_data.size() != 0) begin
                        b = exp_data.pop_front();
                        chk_sym("data_sym", cur, b.s);
                        chk("data_idx", o_data_idx, b.idx);
                        chk("data_last", o_data_last, b.idx == NDATA - 1);
                        beat_cyc.push_back(cyc);
                    end
                end
                stall_prev = o_data_valid && !i_data_ready;
                prev_sym   = cur;
                prev_idx   = o_data_idx;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sym(input bit start, input cplx_sym_t s, input bit chest);
        i_valid      = 1'b1;
        i_slot_start = start;
        i_re         = s.re;
        i_im         = s.im;
        i_chest_done = chest;
        model_in(start, s);
        tick();
        i_valid      = 1'b0;
        i_slot_start = 1'b0;
        i_chest_done = 1'b0;
    endtask

    task automatic pulse_chest();
        i_chest_done = 1'b1;
        tick();
        i_chest_done = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic wait_drain(input int mode, input bit ovf_inj);
        cplx_sym_t s7;
        bit done;
        done = 1'b0;
        for (int k = 0; k < NSC; k++) begin
            s7.re[k] = 16'sh7FFF;
            s7.im[k] = 16'sh7FFF;
        end
        for (int k = 0; k < 300 && !done; k++) begin
            case (mode)
                0: i_data_ready = 1'b1;
                1: i_data_ready = (k % 4 == 0) || (k % 4 == 3);
                default: i_data_ready = 1'($urandom_range(0, 1));
            endcase
            if (ovf_inj && k == 3 && exp_data.size() != 0) begin
                i_valid = 1'b1;
                i_re    = s7.re;
                i_im    = s7.im;
                model_in(1'b0, s7);
            end
            tick();
            i_valid = 1'b0;
            if (exp_data.size() == 0) done = 1'b1;
        end
        i_data_ready = 1'b0;
        chk("drain_complete", exp_data.size(), 0);
        exp_data.delete();
    endtask

    task automatic full_slot_test();
        int m;
        beat_cyc.delete();
        for (int s = 0; s < NSYM; s++) drive_sym(s == 0, pat(s), 1'b0);
        tick();
        chk("wait_est_busy", o_busy, 1);
        chk("wait_est_no_data", o_data_valid, 0);
        m = cyc;
        pulse_chest();
        wait_drain(0, 1'b0);
        chk("full_busy_after", o_busy, 0);
        chk("full_valid_after", o_data_valid, 0);
        chk("full_beats", beat_cyc.size(), NDATA);
        if (beat_cyc.size() == NDATA) begin
            chk("full_first_beat_cyc", beat_cyc[0], m + 1);
            chk("full_last_beat_cyc", beat_cyc[NDATA-1], m + NDATA);
        end
    endtask

    initial begin
        int lastc;
        int cpos;
        // Reset dominates an active slot start and estimate.
        i_rst = 1'b1;
        i_valid = 1'b1;
        i_slot_start = 1'b1;
        i_re = pat(1).re;
        i_im = pat(1).im;
        i_chest_done = 1'b1;
        i_data_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_data_valid", o_data_valid, 0);
        chk("rst_dmrs_valid", o_dmrs_valid, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_slot_err", o_slot_err, 0);
        chk("rst_idx", o_data_idx, 0);
        chk("rst_last", o_data_last, 0);
        chk("rst_dmrs_re0", o_dmrs_re[0], 0);
        chk("rst_data_re0", o_data_re[0], 0);
        i_rst = 1'b0;
        i_valid = 1'b0;
        i_slot_start = 1'b0;
        i_chest_done = 1'b0;
        i_data_ready = 1'b0;
        tick();

        full_slot_test();

        // Estimate two cycles after the DMRS, while still filling.
        beat_cyc.delete();
        for (int s = 0; s < NSYM; s++) drive_sym(s == 0, pat(20 + s), s == DMRS_IDX + 2);
        lastc = cyc - 1;
        wait_drain(0, 1'b0);
        chk("early_beats", beat_cyc.size(), NDATA);
        if (beat_cyc.size() != 0) chk("early_first_beat_cyc", beat_cyc[0], lastc + 2);

        // Back-pressure.
        beat_cyc.delete();
        for (int s = 0; s < NSYM; s++) drive_sym(s == 0, pat(40 + s), 1'b0);
        pulse_chest();
        wait_drain(1, 1'b0);
        chk("bp_beats", beat_cyc.size(), NDATA);

        // Restart on symbol 4, then a clean slot.
        for (int s = 0; s < 4; s++) drive_sym(s == 0, pat(100 + s), 1'b0);
        drive_sym(1'b1, pat(200), 1'b0);
        for (int s = 1; s < NSYM; s++) drive_sym(1'b0, pat(200 + s), 1'b0);
        pulse_chest();
        wait_drain(2, 1'b0);
        chk("restart_err_count", obs_err, exp_err);

        // Overflow in IDLE, WAIT_EST and DRAIN.
        drive_sym(1'b0, rnd_sym(), 1'b0);
        for (int s = 0; s < NSYM; s++) drive_sym(s == 0, rnd_sym(), 1'b0);
        drive_sym(1'b0, rnd_sym(), 1'b0);
        pulse_chest();
        wait_drain(1, 1'b1);
        tick();
        chk("ovf_count", obs_ovf, exp_ovf);

        // Reset after two drained beats.
        for (int s = 0; s < NSYM; s++) drive_sym(s == 0, pat(60 + s), 1'b0);
        i_data_ready = 1'b1;
        pulse_chest();
        for (int k = 0; k < 20 && exp_data.size() > NDATA - 2; k++) tick();
        chk("pre_rst_beats_left", exp_data.size(), NDATA - 2);
        i_rst = 1'b1;
        i_data_ready = 1'b0;
        model_reset();
        tick();
        chk("midrst_valid", o_data_valid, 0);
        chk("midrst_busy", o_busy, 0);
        i_rst = 1'b0;
        tick();
        full_slot_test();

        // Randomized slots.
        for (int n = 0; n < 6; n++) begin
            cpos = $urandom_range(1, NSYM);
            if ($urandom_range(0, 1) == 1) drive_sym(1'b0, rnd_sym(), 1'b0);
            for (int s = 0; s < NSYM; s++) begin
                drive_sym(s == 0, rnd_sym(), s == cpos);
                repeat ($urandom_range(0, 2)) tick();
            end
            if (cpos == NSYM) pulse_chest();
            wait_drain(2, 1'($urandom_range(0, 1)));
        end
        tick();
        chk("final_ovf_count", obs_ovf, exp_ovf);
        chk("final_err_count", obs_err, exp_err);
        chk("final_dmrs_pending", exp_dmrs.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
